// File: rtl/tp_pkg.sv
// tp_pkg: shared types and helpers for the test-port controller.
//   tp_state_t : controller FSM states
//   tp_entry_t : output FIFO entry {idx, data}
//   tp_swap32  : little-endian bus word to readable byte order
//   IDX_W      : width of the capture index
package tp_pkg;

   localparam int unsigned IDX_W = 5;

   typedef enum logic [1:0] {
      StIdle,
      StCapture,
      StDrain,
      StDone
   } tp_state_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [31:0]      data;
   } tp_entry_t;

   function automatic logic [31:0] tp_swap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/testport_ctrl_if.sv
// testport_ctrl_if: CPU data-bus snoop, output stream and status of the test port.
//   bus_addr/bus_wdata/bus_wen : CPU write bus (observed only)
//   out_valid/out_data/out_idx/out_ready : captured-word stream to the checker
//   busy/done/overflow/timed_out/word_count/cycles : session status
// Modports: master = controller side, slave = checker/bus side.
interface testport_ctrl_if;
   import tp_pkg::*;

   logic [29:0]      bus_addr;
   logic [31:0]      bus_wdata;
   logic             bus_wen;
   logic             out_valid;
   logic [31:0]      out_data;
   logic [IDX_W-1:0] out_idx;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic             overflow;
   logic             timed_out;
   logic [IDX_W-1:0] word_count;
   logic [15:0]      cycles;

   modport master (
      input  bus_addr, bus_wdata, bus_wen, out_ready,
      output out_valid, out_data, out_idx, busy, done, overflow, timed_out, word_count, cycles
   );

   modport slave (
      output bus_addr, bus_wdata, bus_wen, out_ready,
      input  out_valid, out_data, out_idx, busy, done, overflow, timed_out, word_count, cycles
   );

endinterface

// File: rtl/tp_fifo.sv
// tp_fifo: synchronous FIFO of tp_entry_t.
//   clk, rst (async, active-low) : clock and reset; reset clears storage
//   push_i/wdata_i : write request; taken when not full, or when full with a pop
//   pop_i          : read request; ignored when empty
//   rdata_o        : head entry
//   full_o/empty_o : occupancy flags
module tp_fifo
   import tp_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push_i,
   input  tp_entry_t wdata_i,
   input  logic      pop_i,
   output tp_entry_t rdata_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

   tp_entry_t        mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q;
   logic [AddrW-1:0] rd_ptr_q;
   logic [AddrW:0]   count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == (AddrW + 1)'(Depth));
   assign empty_o = (count_q == '0);
   assign pop_ok  = pop_i && !empty_o;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok = push_i && (!full_o || pop_ok);
   assign rdata_o = mem_q[rd_ptr_q];

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AddrW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AddrW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (AddrW + 1)'(1);
            2'b01:   count_q <= count_q - (AddrW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/testport_ctrl.sv
// testport_ctrl: capture controller for the memory-mapped test port.
// Snoops CPU writes to PORT_ADDR, byte-swaps them, frames a session between
// BEGIN_SYM and END_SYM and streams captured words with their index.
//   clk, rst (async, active-low)
//   tp_io (testport_ctrl_if.master): bus snoop inputs, output stream, status
// Build option: define TESTPORT_WEN_EDGE_FILTER_EN to accept only the first
// cycle of a write held across D-cache stalls; otherwise every cycle with
// bus_wen high at PORT_ADDR is a separate write (cache-less cores).
module testport_ctrl
   import tp_pkg::*;
#(
   parameter logic [29:0] PORT_ADDR  = 30'h10,
   parameter logic [31:0] BEGIN_SYM  = 32'h00000168,
   parameter logic [31:0] END_SYM    = 32'hFFFFFD5D,
   parameter int unsigned MAX_WORDS  = 31,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
   input logic             clk,
   input logic             rst,
   testport_ctrl_if.master tp_io
);

   localparam logic [IDX_W:0] MaxWords = (IDX_W + 1)'(MAX_WORDS);

   tp_state_t        state_q;
   logic [IDX_W-1:0] word_count_q;
   logic [15:0]      cycles_q;
   logic             overflow_q;
   logic             timed_out_q;
   logic             busy_q;
   logic             done_q;

   logic             hit;
   logic             accept;
   logic [31:0]      swapped;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic             end_hit;
   logic             max_hit;
   logic             tmo_hit;
   tp_entry_t        fifo_wdata;
   tp_entry_t        fifo_rdata;

   assign hit     = tp_io.bus_wen && (tp_io.bus_addr == PORT_ADDR);
   assign swapped = tp_swap32(tp_io.bus_wdata);

`ifdef TESTPORT_WEN_EDGE_FILTER_EN
   logic wen_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wen_q <= 1'b0;
      end else begin
         wen_q <= tp_io.bus_wen;
      end
   end

   // Only the rising edge of bus_wen counts; stall repeats are dropped.
   assign accept = hit && !wen_q;
`else
   assign accept = hit;
`endif

   assign push    = (state_q == StCapture) && accept;
   assign pop     = tp_io.out_valid && tp_io.out_ready;
   assign end_hit = push && (swapped == END_SYM);
   assign max_hit = push && (({1'b0, word_count_q} + (IDX_W + 1)'(1)) == MaxWords);
   assign tmo_hit = (cycles_q == (TIMEOUT - 16'd1));

   assign fifo_wdata.idx  = word_count_q;
   assign fifo_wdata.data = swapped;

   tp_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (fifo_wdata),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         word_count_q <= '0;
         cycles_q     <= '0;
         overflow_q   <= 1'b0;
         timed_out_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept && (swapped == BEGIN_SYM)) begin
                  state_q      <= StCapture;
                  word_count_q <= '0;
                  cycles_q     <= '0;
                  busy_q       <= 1'b1;
               end
            end
            StCapture: begin
               if (cycles_q != 16'hFFFF) begin
                  cycles_q <= cycles_q + 16'd1;
               end
               if (push) begin
                  word_count_q <= word_count_q + IDX_W'(1);
                  // Dropped words still consume an index so the checker sees a gap.
                  if (fifo_full && !pop) begin
                     overflow_q <= 1'b1;
                  end
               end
               if (end_hit) begin
                  state_q <= StDrain;
               end else begin
                  if (max_hit) begin
                     state_q <= StDrain;
                  end
                  if (tmo_hit) begin
                     timed_out_q <= 1'b1;
                     state_q     <= StDrain;
                  end
               end
            end
            StDrain: begin
               if (fifo_empty) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StDone;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign tp_io.out_valid  = !fifo_empty;
   assign tp_io.out_data   = fifo_rdata.data;
   assign tp_io.out_idx    = fifo_rdata.idx;
   assign tp_io.busy       = busy_q;
   assign tp_io.done       = done_q;
   assign tp_io.overflow   = overflow_q;
   assign tp_io.timed_out  = timed_out_q;
   assign tp_io.word_count = word_count_q;
   assign tp_io.cycles     = cycles_q;

endmodule

// File: tb/tb_testport_ctrl.sv
// tb_testport_ctrl: scoreboard bench for testport_ctrl.
// Stimulus pushes expected {idx, data} into a queue; a monitor pops and
// compares on every handshake. A second instance with a short timeout
// covers the timeout path.
module tb_testport_ctrl;
   import tp_pkg::*;

   logic clk;
   logic rst;

   testport_ctrl_if tp ();
   testport_ctrl_if tp_t ();

   testport_ctrl u_dut (
      .clk   (clk),
      .rst   (rst),
      .tp_io (tp)
   );

   testport_ctrl #(
      .TIMEOUT (16'd20)
   ) u_dut_t (
      .clk   (clk),
      .rst   (rst),
      .tp_io (tp_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int        checks   = 0;
   int        failures = 0;
   tp_entry_t exp_q[$];
   logic      saw_valid_t = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [IDX_W-1:0] idx, input logic [31:0] data);
      tp_entry_t e;
      e.idx  = idx;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Entered and left just after a rising edge; wen held for `hold` cycles,
   // then low for one cycle.
   task automatic wr(input logic [29:0] a, input logic [31:0] d, input int hold);
      tp.bus_addr  = a;
      tp.bus_wdata = d;
      tp.bus_wen   = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      tp.bus_wen = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name, input int lim);
      int n = 0;
      while (!tp.done && n < lim) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, 32'(tp.done), 32'd1);
   endtask

   // Scoreboard monitor: a handshake seen at the falling edge completes at
   // the next rising edge.
   always @(negedge clk) begin
      if (rst && tp.out_valid && tp.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pop: got idx %0d data 0x%08h expected none",
                     tp.out_idx, tp.out_data);
         end else begin
            tp_entry_t e;
            e = exp_q.pop_front();
            chk("pop_idx", 32'(tp.out_idx), 32'(e.idx));
            chk("pop_data", tp.out_data, e.data);
         end
      end
      if (rst && tp_t.out_valid) saw_valid_t = 1'b1;
   end

   initial begin
      rst            = 1'b0;
      tp.bus_addr    = '0;
      tp.bus_wdata   = '0;
      tp.bus_wen     = 1'b0;
      tp.out_ready   = 1'b0;
      tp_t.bus_addr  = '0;
      tp_t.bus_wdata = '0;
      tp_t.bus_wen   = 1'b0;
      tp_t.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset values, sampled while reset is held.
      chk("rst_out_valid", 32'(tp.out_valid), 32'd0);
      chk("rst_out_data", tp.out_data, 32'd0);
      chk("rst_out_idx", 32'(tp.out_idx), 32'd0);
      chk("rst_busy", 32'(tp.busy), 32'd0);
      chk("rst_done", 32'(tp.done), 32'd0);
      chk("rst_overflow", 32'(tp.overflow), 32'd0);
      chk("rst_timed_out", 32'(tp.timed_out), 32'd0);
      chk("rst_word_count", 32'(tp.word_count), 32'd0);
      chk("rst_cycles", 32'(tp.cycles), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Idle noise: non-begin data at the port, begin symbol at the wrong address.
      tp.out_ready = 1'b1;
      wr(30'h10, 32'h12345678, 1);
      wr(30'h11, 32'h68010000, 1);
      chk("idle_busy", 32'(tp.busy), 32'd0);
      chk("idle_out_valid", 32'(tp.out_valid), 32'd0);

      // Session with a 3-cycle stalled write.
      wr(30'h10, 32'h68010000, 1);
      chk("sess_busy", 32'(tp.busy), 32'd1);
`ifdef TESTPORT_WEN_EDGE_FILTER_EN
      exp_push(5'd0, 32'h0000DEAD);
      exp_push(5'd1, 32'hFFFFFD5D);
`else
      exp_push(5'd0, 32'h0000DEAD);
      exp_push(5'd1, 32'h0000DEAD);
      exp_push(5'd2, 32'h0000DEAD);
      exp_push(5'd3, 32'hFFFFFD5D);
`endif
      wr(30'h10, 32'hADDE0000, 3);
      wr(30'h10, 32'h5DFDFFFF, 1);
      wait_done("sess_done", 50);
`ifdef TESTPORT_WEN_EDGE_FILTER_EN
      chk("sess_word_count", 32'(tp.word_count), 32'd2);
`else
      chk("sess_word_count", 32'(tp.word_count), 32'd4);
`endif
      chk("sess_overflow", 32'(tp.overflow), 32'd0);
      chk("sess_timed_out", 32'(tp.timed_out), 32'd0);
      chk("sess_busy_end", 32'(tp.busy), 32'd0);
      chk("sess_q_empty", 32'(exp_q.size()), 32'd0);

      // Backpressure: six words into a 4-entry FIFO, then END_SYM (also dropped).
      do_reset();
      tp.out_ready = 1'b0;
      wr(30'h10, 32'h68010000, 1);
      exp_push(5'd0, 32'h00000001);
      exp_push(5'd1, 32'h00000002);
      exp_push(5'd2, 32'h00000003);
      exp_push(5'd3, 32'h00000004);
      for (int i = 1; i <= 6; i++) begin
         wr(30'h10, 32'(i) << 24, 1);
      end
      chk("bp_word_count", 32'(tp.word_count), 32'd6);
      chk("bp_overflow", 32'(tp.overflow), 32'd1);
      chk("bp_out_valid", 32'(tp.out_valid), 32'd1);
      chk("bp_head_idx", 32'(tp.out_idx), 32'd0);
      chk("bp_head_data", tp.out_data, 32'h00000001);
      wr(30'h10, 32'h5DFDFFFF, 1);
      chk("bp_word_count_end", 32'(tp.word_count), 32'd7);
      chk("bp_not_done", 32'(tp.done), 32'd0);
      tp.out_ready = 1'b1;
      wait_done("bp_done", 50);
      chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

      // Mid-session reset discards the FIFO; a new session restarts at idx 0.
      do_reset();
      tp.out_ready = 1'b0;
      wr(30'h10, 32'h68010000, 1);
      wr(30'h10, 32'h21000000, 1);
      wr(30'h10, 32'h22000000, 1);
      chk("mid_out_valid_pre", 32'(tp.out_valid), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("mid_out_valid", 32'(tp.out_valid), 32'd0);
      chk("mid_out_data", tp.out_data, 32'd0);
      chk("mid_word_count", 32'(tp.word_count), 32'd0);
      chk("mid_busy", 32'(tp.busy), 32'd0);
      @(posedge clk);
      #1;
      tp.out_ready = 1'b1;
      exp_push(5'd0, 32'h0000000B);
      exp_push(5'd1, 32'hFFFFFD5D);
      wr(30'h10, 32'h68010000, 1);
      wr(30'h10, 32'h0B000000, 1);
      wr(30'h10, 32'h5DFDFFFF, 1);
      wait_done("mid_done", 50);
      chk("mid_q_empty", 32'(exp_q.size()), 32'd0);

      // Timeout on the short-timeout instance: begin, then silence.
      do_reset();
      tp_t.bus_addr  = 30'h10;
      tp_t.bus_wdata = 32'h68010000;
      tp_t.bus_wen   = 1'b1;
      @(posedge clk);
      #1;
      tp_t.bus_wen = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk("tmo_before", 32'(tp_t.timed_out), 32'd0);
      chk("tmo_cycles_19", 32'(tp_t.cycles), 32'd19);
      @(posedge clk);
      #1;
      chk("tmo_flag", 32'(tp_t.timed_out), 32'd1);
      chk("tmo_cycles_20", 32'(tp_t.cycles), 32'd20);
      begin
         int n = 0;
         while (!tp_t.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      chk("tmo_done", 32'(tp_t.done), 32'd1);
      chk("tmo_word_count", 32'(tp_t.word_count), 32'd0);
      chk("tmo_no_valid", 32'(saw_valid_t), 32'd0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/testport_ctrl.md
# testport_ctrl

Controller for the memory-mapped test port at word address 0x10. It watches CPU data-bus writes and filters out the repeated write cycles caused by D-cache stalls. It byte-swaps each accepted word from little-endian to readable order and runs a capture session framed by begin and end symbols. Captured words are buffered and streamed to the result checker over a valid/ready handshake, with index, cycle count and error flags.

## Interface
- PORT_ADDR, 30'h10, word address of the test port
- BEGIN_SYM, 32'h00000168, session start symbol (after swap)
- END_SYM, 32'hFFFFFD5D, session end symbol (after swap)
- MAX_WORDS, 31, capture limit including END_SYM; index width is 5 bits
- FIFO_DEPTH, 4, output buffer entries (power of two)
- TIMEOUT, 16'hFFFF, capture cycle limit
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- bus_addr  in  30  CPU data-bus word address
- bus_wdata  in  32  CPU write data, little-endian
- bus_wen  in  1  CPU write enable; held high across D-cache stall cycles
- out_valid  out  1  buffered word available
- out_data  out  32  swapped word, FIFO head
- out_idx  out  5  capture index of out_data, 0-based
- out_ready  in  1  checker accepts the head word
- busy  out  1  state is CAPTURE or DRAIN
- done  out  1  state is DONE
- overflow  out  1  sticky; a word was dropped because the FIFO was full
- timed_out  out  1  sticky; capture ended by TIMEOUT
- word_count  out  5  accepted capture writes, including dropped words
- cycles  out  16  cycles spent in CAPTURE, saturating

## Operation
- swap = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]}.
- Accepted write (filter on): bus_wen && bus_addr==PORT_ADDR && !wen_q. wen_q is bus_wen registered every cycle, in every state.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE:
  - Accepted write with swap==BEGIN_SYM: go to CAPTURE. BEGIN_SYM is not pushed; word_count and cycles clear to 0.
  - All other accepted writes are ignored.
- CAPTURE:
  - cycles increments every cycle and saturates at 16'hFFFF.
  - Each accepted write pushes {word_count, swap} and increments word_count.
  - If swap==END_SYM, push it, then go to DRAIN.
  - Else if word_count+1==MAX_WORDS, go to DRAIN.
  - If cycles==TIMEOUT-1 with no END_SYM, set timed_out and go to DRAIN.
  - END_SYM and timeout in the same cycle: END_SYM wins; timed_out stays 0.
  - BEGIN_SYM seen again inside CAPTURE is captured as plain data.
- Push into a full FIFO: the word is dropped, overflow is set, word_count still increments, so the checker sees an index gap. A full FIFO with a simultaneous pop accepts the push.
- DRAIN: no new captures. Go to DONE on the cycle the FIFO becomes empty.
- DONE: terminal; done=1 until reset. Counters and flags hold.
- Pop occurs when out_valid && out_ready, in any state.

## Timing
- Reset values: state IDLE; out_valid, out_data, out_idx, busy, done, overflow, timed_out, word_count, cycles all 0; wen_q 0; FIFO empty.
- Push at edge N: out_valid is high in cycle N+1 (1-cycle latency).
- out_data and out_idx are stable while out_valid && !out_ready. The head advances the cycle after a pop.
- A stalled write with bus_wen high for K cycles yields exactly one capture. Two writes need bus_wen low for at least 1 cycle between them.
- busy and done are decoded from registered state and change in the cycle after the transition edge.
- Reset asserted mid-session returns to IDLE immediately and discards FIFO contents.

## Configuration
- TESTPORT_WEN_EDGE_FILTER_EN defined: the acceptance rule above applies, including !wen_q.
- Not defined: every cycle with bus_wen && bus_addr==PORT_ADDR is accepted. wen_q is not instantiated. This mode is for cache-less cores only.

## Structure
- Package tp_pkg:
  - state enum tp_state_t.
  - function tp_swap32.
  - localparam IDX_W=5.
  - FIFO entry struct tp_entry_t {idx, data}.
- Sub-module tp_fifo: synchronous FIFO of tp_entry_t, depth FIFO_DEPTH, with full/empty flags, push/pop, simultaneous push-when-full-with-pop support.
- Top level holds the FSM, the write filter, the counters and the sticky flags.

## Test plan
- Session with stall: write 0x68010000 (swaps to BEGIN_SYM), then 0xADDE0000 with bus_wen held 3 cycles, then 0x5DFDFFFF, out_ready=1 -> out words (0, 0x0000DEAD), (1, END_SYM); word_count=2; done=1; overflow=0.
- Backpressure: out_ready=0, six data words after begin -> first four captured, overflow=1, word_count=6. Release out_ready -> idx 0..3 popped in order, then done.
- Timeout: TIMEOUT=16'd20, begin then no writes -> timed_out=1 at cycle 20 of CAPTURE, done=1, word_count=0.
- Idle noise: writes 0x12345678 to address 0x10 and BEGIN_SYM to address 0x11 while IDLE -> busy stays 0, no out_valid.
- Mid-session reset: begin, 2 words, rst low 1 cycle -> all outputs 0, FIFO empty; a new begin restarts with idx 0.
- Filter off (macro undefined): one data write with bus_wen held 3 cycles -> three captures, idx 0, 1, 2.
